uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and data width.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 625;
    localparam int DATA_W               = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is dropped
// unless a read retires the head in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign drop  = wr_en && !wr_ok;

    // Head is forced to zero while empty so the output is defined out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; every entry is written before it can be read,
    // and leaving it out keeps the array mappable onto plain RAM/flops without reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values and simulation order between processes cannot matter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a receive FIFO with a
// valid/ready consumer port, plus framing-error and overrun pulses.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          RX,
    output logic [DATA_W-1:0]             M_DATA,
    output logic                          M_VALID,
    input  logic                          M_READY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic              rx_meta;
    logic              rx_sync;
    logic [1:0]        sync_ok;
    rx_state_e         state,   state_next;
    logic [CNT_W-1:0]  cnt,     cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [DATA_W-1:0] shift,   shift_next;
    logic              armed,   armed_next;
    logic              push;
    logic              frame_err_next;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_drop;

    // sync_ok marks when the synchronizer holds line data rather than its reset value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            sync_ok <= 2'b00;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            sync_ok <= {sync_ok[0], 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            armed     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            armed     <= armed_next;
            FRAME_ERR <= frame_err_next;
            OVERRUN   <= fifo_drop;
        end
    end

    // NOTE: every output of this block is given a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        armed_next     = armed;
        push           = 1'b0;
        frame_err_next = 1'b0;

        unique case (state)
            // A start needs a real high-to-low transition, so a line that is
            // already low after reset or after a bad stop bit is ignored.
            IDLE: begin
                if (armed && !rx_sync) begin
                    cnt_next   = HALF_LOAD;
                    armed_next = 1'b0;
                    state_next = START;
                end else if (rx_sync && sync_ok[1]) begin
                    armed_next = 1'b1;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (!rx_sync) begin
                    cnt_next     = BIT_LOAD;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shift_next   = {rx_sync, shift[DATA_W-1:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    cnt_next     = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    if (rx_sync) begin
                        push = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop     = M_VALID && M_READY;
    assign M_VALID = !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en   (push),
        .wr_data (shift),
        .rd_en   (pop),
        .rd_data (M_DATA),
        .empty   (fifo_empty),
        .count   (COUNT),
        .drop    (fifo_drop)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames drive a byte scoreboard
// that is checked as the consumer port pops.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       CLK;
    logic       RST_N;
    logic       RX;
    logic [7:0] M_DATA;
    logic       M_VALID;
    logic       M_READY;
    logic [3:0] COUNT;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         long_pulse = 0;
    bit         fe_prev = 0;
    bit         ov_prev = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RX        (RX),
        .M_DATA    (M_DATA),
        .M_VALID   (M_VALID),
        .M_READY   (M_READY),
        .COUNT     (COUNT),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: counts pulses, flags stretched pulses, scores every pop.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (FRAME_ERR) fe_cnt++;
            if (OVERRUN) ov_cnt++;
            if ((FRAME_ERR && fe_prev) || (OVERRUN && ov_prev)) long_pulse++;
            fe_prev = FRAME_ERR;
            ov_prev = OVERRUN;
            if (M_VALID && M_READY) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'(M_DATA), 32'h100);
                else check("pop_data", 32'(M_DATA), 32'(exp_q.pop_front()));
            end
        end else begin
            fe_prev = 0;
            ov_prev = 0;
        end
    end

    // One 8N1 frame plus one idle bit; 'pulse' raises M_READY only for the
    // cycle whose edge samples the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit pulse);
        logic [10:0] fr;
        fr = {1'b1, stop_bit, b, 1'b0};
        if (!stop_bit) exp_fe++;
        else if (exp_q.size() < DEPTH || pulse) exp_q.push_back(b);
        else exp_ov++;
        @(posedge CLK); #1;
        for (int c = 0; c < 11 * CPB; c++) begin
            RX = fr[c / CPB];
            if (pulse && c == 154) M_READY = 1'b1;
            if (pulse && c == 155) M_READY = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        M_READY = 1'b1;
        while (M_VALID && n < 4 * DEPTH) begin
            @(posedge CLK); #1;
            n++;
        end
        M_READY = 1'b0;
        check({tag, "_valid_low"}, 32'(M_VALID), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        check({tag, "_count_zero"}, 32'(COUNT), 32'd0);
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_frame_err"}, fe_cnt, exp_fe);
        check({tag, "_overrun"}, ov_cnt, exp_ov);
    endtask

    initial begin
        logic [10:0] fr;
        RST_N   = 1'b0;
        RX      = 1'b1;
        M_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", 32'(M_VALID), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_data", 32'(M_DATA), 32'd0);
        check("rst_frame_err", 32'(FRAME_ERR), 32'd0);
        check("rst_overrun", 32'(OVERRUN), 32'd0);
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);

        // Single byte, consumer stalled.
        send_byte(8'h41, 1'b1, 0);
        check("b41_valid", 32'(M_VALID), 32'd1);
        check("b41_data", 32'(M_DATA), 32'h41);
        check("b41_count", 32'(COUNT), exp_q.size());
        check_pulses("b41");
        drain("b41");

        // Bad stop bit, then a good byte.
        send_byte(8'h00, 1'b0, 0);
        check_pulses("badstop");
        check("badstop_count", 32'(COUNT), 32'd0);
        send_byte(8'h5A, 1'b1, 0);
        check("b5a_data", 32'(M_DATA), 32'h5A);
        drain("b5a");

        // Short low glitch is rejected at the start-bit check.
        @(posedge CLK); #1;
        RX = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RX = 1'b1;
        exp_fe++;
        repeat (3 * CPB) @(posedge CLK);
        #1;
        check_pulses("glitch");
        check("glitch_count", 32'(COUNT), 32'd0);

        // M_READY held with nothing queued, then a byte falls through and pops.
        M_READY = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("ready_empty_count", 32'(COUNT), 32'd0);
        send_byte(8'hC3, 1'b1, 0);
        check("c3_popped", exp_q.size(), 32'd0);
        M_READY = 1'b0;

        // Fill past capacity: ninth byte overruns.
        for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i), 1'b1, 0);
        check("full_count", 32'(COUNT), 32'(DEPTH));
        check_pulses("full");
        drain("full");

        // Full FIFO with a pop coinciding with the ninth push.
        for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b1, 0);
        send_byte(8'(DEPTH + 1), 1'b1, 1);
        check("pushpop_count", 32'(COUNT), 32'(DEPTH));
        check_pulses("pushpop");
        drain("pushpop");

        // Reset mid-frame with one byte queued.
        send_byte(8'h11, 1'b1, 0);
        fr = {1'b1, 1'b1, 8'hA5, 1'b0};
        @(posedge CLK); #1;
        for (int c = 0; c < 11 * CPB; c++) begin
            RX = fr[c / CPB];
            if (c == 88) begin
                RST_N = 1'b0;
                exp_q.delete();
            end
            if (c == 136) RST_N = 1'b1;
            @(posedge CLK); #1;
        end
        check("rst_mid_count", 32'(COUNT), 32'd0);
        check("rst_mid_valid", 32'(M_VALID), 32'd0);
        check_pulses("rst_mid");
        send_byte(8'h3C, 1'b1, 0);
        check("b3c_data", 32'(M_DATA), 32'h3C);
        check("b3c_count", 32'(COUNT), 32'd1);
        drain("b3c");

        check_pulses("final");
        check("pulse_width", long_pulse, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
